// File: rtl/imem_loader.sv
// Instruction-memory port owner: passes fetch accesses through in run mode and
// writes a UART-delivered program (16-bit word count, then MSB-first words) in load mode.
module imem_loader #(
   parameter int unsigned ADDR_W    = 14,
   parameter int unsigned MAX_WORDS = 16384
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load_mode,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [31:0]       instruction_o,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_we,
   input  logic [31:0]       mem_rdata,
   output logic              cpu_rst,
   output logic              load_done,
   output logic              load_error
);

   localparam int unsigned LEN_W = 16;

   typedef enum logic [2:0] {
      S_RUN,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_DONE,
      S_ERR
   } state_t;

   state_t             state;
   logic [ADDR_W-1:0]  word_addr;
   logic [1:0]         byte_idx;
   logic [LEN_W-1:0]   len;
   logic [23:0]        asm_q;
   logic               load_mode_q;
   logic               load_rise;
   logic [LEN_W-1:0]   len_next;
   logic               last_word;

   assign load_rise = load_mode & ~load_mode_q;
   assign len_next  = {len[15:8], rx_data};
   assign last_word = (32'(word_addr) + 32'd1) == 32'(len);

   // Memory port mux: fetch owns the address only while running
   always_comb begin
      mem_addr      = word_addr;
      instruction_o = 32'h0000_0000;
      if (state == S_RUN) begin
         mem_addr      = fetch_addr;
         instruction_o = mem_rdata;
      end
   end

   assign cpu_rst = reset | (state != S_RUN);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= S_RUN;
         word_addr   <= '0;
         byte_idx    <= '0;
         len         <= '0;
         asm_q       <= '0;
         mem_we      <= 1'b0;
         mem_wdata   <= '0;
         load_done   <= 1'b0;
         load_error  <= 1'b0;
         load_mode_q <= 1'b0;
      end else begin
         load_mode_q <= load_mode;
         mem_we      <= 1'b0;
         // Address advances as the one-cycle write retires
         if (mem_we) begin
            word_addr <= word_addr + ADDR_W'(1);
         end

         case (state)
            S_RUN: begin
               if (load_rise) begin
                  state      <= S_LEN_HI;
                  word_addr  <= '0;
                  byte_idx   <= '0;
                  len        <= '0;
                  load_done  <= 1'b0;
                  load_error <= 1'b0;
               end
            end

            S_LEN_HI: begin
               if (!load_mode) begin
                  state      <= S_ERR;
                  load_error <= 1'b1;
               end else if (rx_valid) begin
                  len[15:8] <= rx_data;
                  state     <= S_LEN_LO;
               end
            end

            S_LEN_LO: begin
               if (!load_mode) begin
                  state      <= S_ERR;
                  load_error <= 1'b1;
               end else if (rx_valid) begin
                  len <= len_next;
                  if (len_next == '0 || 32'(len_next) > MAX_WORDS) begin
                     state      <= S_ERR;
                     load_error <= 1'b1;
                  end else begin
                     state <= S_DATA;
                  end
               end
            end

            S_DATA: begin
               if (!load_mode) begin
                  state      <= S_ERR;
                  load_error <= 1'b1;
               end else begin
                  // Assembly and write registers are separate so a byte in the write cycle is kept
                  if (rx_valid) begin
                     asm_q    <= {asm_q[15:0], rx_data};
                     byte_idx <= byte_idx + 2'd1;
                     if (byte_idx == 2'd3) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= {asm_q, rx_data};
                     end
                  end
                  if (mem_we && last_word) begin
                     state     <= S_DONE;
                     load_done <= 1'b1;
                  end
               end
            end

            S_DONE: begin
               if (!load_mode) begin
                  state     <= S_RUN;
                  load_done <= 1'b0;
               end
            end

            S_ERR: begin
               if (load_rise) begin
                  state      <= S_LEN_HI;
                  word_addr  <= '0;
                  byte_idx   <= '0;
                  len        <= '0;
                  load_done  <= 1'b0;
                  load_error <= 1'b0;
               end
            end

            default: state <= S_RUN;
         endcase
      end
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Sits directly upstream of the instruction-fetch stage and owns the instruction-memory port.
- In run mode it passes the fetch word address to the instruction BRAM and returns the fetched word to fetch.
- In load mode it receives a program as a byte stream from the UART receiver, packs the bytes into 32-bit words and writes them sequentially into the BRAM. It holds the CPU in reset for the whole load.

Parameters:
ADDR_W, 14, word-address width of instruction memory (matches fetch addr_o)
MAX_WORDS, 16384, largest accepted program length in words

Ports:
clock  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
load_mode  input  1  board switch selecting program load; synchronised externally
rx_data  input  8  received UART byte
rx_valid  input  1  one-cycle strobe, rx_data valid; may assert every cycle
fetch_addr  input  ADDR_W  word address from fetch stage
instruction_o  output  32  instruction word to fetch stage
mem_addr  output  ADDR_W  BRAM word address
mem_wdata  output  32  BRAM write data
mem_we  output  1  BRAM write enable
mem_rdata  input  32  BRAM read data
cpu_rst  output  1  reset to the rest of the CPU, active-high
load_done  output  1  program fully written
load_error  output  1  load aborted

Behaviour:
- Reset values: state=RUN, word_addr=0, byte_idx=0, len=0, mem_we=0, mem_wdata=0, load_done=0, load_error=0, load_mode_q=0.
- cpu_rst = reset OR (state != RUN).
- States are RUN, LEN_HI, LEN_LO, DATA, DONE and ERR.
- load_mode_q is a registered copy of load_mode. load_rise = load_mode & ~load_mode_q.
- RUN:
  - mem_addr = fetch_addr (combinational).
  - instruction_o = mem_rdata.
  - mem_we = 0.
  - On load_rise: go to LEN_HI; clear word_addr, byte_idx, load_done and load_error.
- Outside RUN: mem_addr = word_addr and instruction_o = 32'h0000_0000 (NOP).
- LEN_HI: on rx_valid, len[15:8] = rx_data; go to LEN_LO.
- LEN_LO: on rx_valid, len[7:0] = rx_data.
  - If the assembled 16-bit length is 0 or > MAX_WORDS: go to ERR.
  - Otherwise: go to DATA.
- DATA: bytes arrive MSB first.
  - On rx_valid, shift the byte into the assembly register and increment byte_idx (mod 4).
  - On the 4th byte (byte_idx==3) at cycle t, at t+1: mem_we=1, mem_wdata=packed word, mem_addr=word_addr. word_addr increments after the write.
  - mem_we is high for exactly one cycle per word.
  - The write register is separate from the assembly register, so a byte arriving in cycle t+1 is accepted without loss.
  - After writing word number len-1: go to DONE in the same cycle the write completes.
  - Bytes beyond the declared length are ignored in DONE.
- DONE: load_done=1, CPU held in reset. When load_mode goes low: go to RUN, clear load_done, and deassert cpu_rst on the next cycle.
- ERR: load_error=1 (sticky), cpu_rst=1, no writes. Leave only on load_rise, to LEN_HI with counters cleared.
- load_mode low while in LEN_HI, LEN_LO or DATA: go to ERR next cycle. A write already scheduled for that cycle still completes.
- rx_valid in RUN is ignored.
- word_addr wraps at 2^ADDR_W, which is unreachable when MAX_WORDS ≤ 2^ADDR_W.
- Asynchronous reset mid-load: immediately return to RUN. BRAM contents already written are kept; the partially assembled word is dropped.

Test Plan:
- Reset, then load_mode=0, fetch_addr=14'h0005 with mem_rdata=32'h2008000A -> mem_addr=0x0005, instruction_o=32'h2008000A, cpu_rst=0, mem_we never 1.
- load_mode 0->1, then bytes 00 02 20 08 00 0A 01 09 50 20 sent back to back -> mem_we pulses twice: addr 0 data 32'h2008000A, then addr 1 data 32'h01095020. After that load_done=1 and cpu_rst=1. Dropping load_mode gives RUN with cpu_rst=0 one cycle later.
- Length bytes 00 00 -> ERR, load_error=1, no writes. load_mode low->high restarts in LEN_HI with load_error cleared.
- Length 0x4001 with MAX_WORDS=16384 -> ERR, load_error=1, cpu_rst=1.
- Length 3, load_mode dropped after 6 data bytes -> exactly one write (addr 0), then ERR with load_error=1. rx_valid afterwards causes no write.
- Asynchronous reset pulse mid-DATA after 2 bytes -> cpu_rst follows reset, state RUN after release, load_done=0, load_error=0, no stray mem_we.
